// File: rtl/fetch_id_requester.sv
// Fetch-side ID requester: claims instruction IDs, issues in-order memory reads,
// and returns completions in assignment order, discarding responses owed across a flush.
module fetch_id_requester #(
    parameter logic [31:0] RESET_VECTOR    = 32'h8000_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_flush,
    input  logic [31:0] flush_pc,
    input  logic        pc_id_available,
    output logic        pc_id_assigned,
    output logic [31:0] if_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerror,
    output logic        fetch_complete,
    output logic [31:0] fetch_instruction,
    output logic        fetch_ok,
    output logic [4:0]  fetch_error_code
);
    localparam int            CW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW:0]   CAP = MAX_OUTSTANDING[CW:0];

    logic [31:0]   pc;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic          misaligned_pending;

    logic          aligned;
    logic          can_issue;
    logic          issue_mem;
    logic          rsp_live;
    logic          rsp_drop;
    logic          misaligned_done;
    logic [CW:0]   inflight;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        aligned         = (pc[1:0] == 2'b00);
        inflight        = {1'b0, live} + {1'b0, drop};
        can_issue       = pc_id_available & ~fetch_flush & ~misaligned_pending & (inflight < CAP);
        mem_req         = ~rst & aligned & can_issue;
        pc_id_assigned  = ~rst & (aligned ? (can_issue & mem_ack) : can_issue);
        issue_mem       = pc_id_assigned & aligned;
        rsp_drop        = mem_rvalid & (drop != '0);
        rsp_live        = mem_rvalid & (drop == '0);
        // A misaligned fetch reports only after every older read has drained.
        misaligned_done = misaligned_pending & (live == '0) & (drop == '0) & ~mem_rvalid;
    end

    assign if_pc    = pc;
    assign mem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                 <= RESET_VECTOR;
            live               <= '0;
            drop               <= '0;
            misaligned_pending <= 1'b0;
            fetch_complete     <= 1'b0;
            fetch_instruction  <= '0;
            fetch_ok           <= 1'b0;
            fetch_error_code   <= '0;
        end else begin
            fetch_complete <= 1'b0;
            if (fetch_flush) begin
                // Everything still owed by memory, including a response landing now, is dropped.
                pc                 <= flush_pc;
                drop               <= drop + live - CW'(mem_rvalid);
                live               <= '0;
                misaligned_pending <= 1'b0;
            end else begin
                if (issue_mem) begin
                    pc <= pc + 32'd4;
                end
                if (pc_id_assigned && !aligned) begin
                    misaligned_pending <= 1'b1;
                end
                live <= live + CW'(issue_mem) - CW'(rsp_live);
                drop <= drop - CW'(rsp_drop);
                if (rsp_live) begin
                    fetch_complete    <= 1'b1;
                    fetch_instruction <= mem_rdata;
                    fetch_ok          <= ~mem_rerror;
                    fetch_error_code  <= mem_rerror ? 5'd1 : 5'd0;
                end else if (misaligned_done) begin
                    fetch_complete     <= 1'b1;
                    fetch_instruction  <= '0;
                    fetch_ok           <= 1'b0;
                    fetch_error_code   <= 5'd0;
                    misaligned_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_id_requester.sv
// Self-checking bench for fetch_id_requester: directed steps then random traffic,
// checked against a queue-based model of reads in flight.
module tb_fetch_id_requester;
    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam int          MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_flush;
    logic [31:0] flush_pc;
    logic        pc_id_available;
    logic        pc_id_assigned;
    logic [31:0] if_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerror;
    logic        fetch_complete;
    logic [31:0] fetch_instruction;
    logic        fetch_ok;
    logic [4:0]  fetch_error_code;

    always #5 clk = ~clk;

    fetch_id_requester #(.RESET_VECTOR(RV), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .fetch_flush(fetch_flush), .flush_pc(flush_pc),
        .pc_id_available(pc_id_available), .pc_id_assigned(pc_id_assigned),
        .if_pc(if_pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerror(mem_rerror),
        .fetch_complete(fetch_complete), .fetch_instruction(fetch_instruction),
        .fetch_ok(fetch_ok), .fetch_error_code(fetch_error_code)
    );

    // Each read in flight: its address, the word memory will return, and whether a flush orphaned it.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          discard;
    } rd_t;

    rd_t         q[$];
    logic [31:0] m_pc;
    bit          m_mis;
    bit          hold;
    bit          e_cpl;
    logic [31:0] e_ins;
    bit          e_ok;
    logic [4:0]  e_code;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = RV;
        m_mis  = 0;
        hold   = 0;
        e_cpl  = 0;
        e_ins  = '0;
        e_ok   = 0;
        e_code = '0;
    endtask

    task automatic do_reset();
        rst = 1; pc_id_available = 1; mem_ack = 1; fetch_flush = 0; flush_pc = '0;
        mem_rvalid = 0; mem_rdata = '0; mem_rerror = 0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_assigned", 32'(pc_id_assigned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0; pc_id_available = 0; mem_ack = 0;
        model_reset();
        #1;
        chk("rst_if_pc", if_pc, RV);
        chk("rst_mem_addr", mem_addr, RV);
        chk("rst_complete", 32'(fetch_complete), 32'd0);
        chk("rst_instr", fetch_instruction, 32'd0);
        chk("rst_ok", 32'(fetch_ok), 32'd0);
        chk("rst_code", 32'(fetch_error_code), 32'd0);
        chk("rst_idle_req", 32'(mem_req), 32'd0);
        @(negedge clk);
    endtask

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic cycle(input bit avail, input bit ack, input bit rsp, input bit err,
                         input bit flush, input logic [31:0] fpc);
        bit   resp, can, exp_req, exp_asg;
        rd_t  e;
        if (hold) avail = 1;
        resp = rsp && (q.size() > 0);
        pc_id_available = avail;
        mem_ack         = ack;
        fetch_flush     = flush;
        flush_pc        = fpc;
        mem_rvalid      = resp;
        mem_rdata       = resp ? q[0].data : $urandom;
        mem_rerror      = resp ? err : 1'b0;
        can     = avail && !flush && !m_mis && (q.size() < MAXO);
        exp_req = can && (m_pc[1:0] == 2'b00);
        exp_asg = (m_pc[1:0] == 2'b00) ? (exp_req && ack) : can;
        #1;
        chk("if_pc", if_pc, m_pc);
        chk("mem_addr", mem_addr, m_pc);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("assigned", 32'(pc_id_assigned), 32'(exp_asg));
        chk("complete", 32'(fetch_complete), 32'(e_cpl));
        if (e_cpl) begin
            chk("instr", fetch_instruction, e_ins);
            chk("ok", 32'(fetch_ok), 32'(e_ok));
            chk("code", 32'(fetch_error_code), 32'(e_code));
        end
        e_cpl = 0;
        if (resp) begin
            e = q.pop_front();
            if (!e.discard && !flush) begin
                e_cpl  = 1;
                e_ins  = e.data;
                e_ok   = !err;
                e_code = err ? 5'd1 : 5'd0;
            end
        end else if (m_mis && q.size() == 0 && !flush) begin
            e_cpl  = 1;
            e_ins  = '0;
            e_ok   = 0;
            e_code = 5'd0;
            m_mis  = 0;
        end
        if (flush) begin
            foreach (q[i]) q[i].discard = 1;
            m_pc  = fpc;
            m_mis = 0;
        end else if (exp_asg) begin
            if (m_pc[1:0] == 2'b00) begin
                e.addr = m_pc; e.data = $urandom; e.discard = 0;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end else begin
                m_mis = 1;
            end
        end
        hold = exp_req && !ack;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 1, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, '0);
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] fpc;
        rst = 1; fetch_flush = 0; flush_pc = '0; pc_id_available = 0; mem_ack = 0;
        mem_rvalid = 0; mem_rdata = '0; mem_rerror = 0;
        @(negedge clk);
        do_reset();

        // Four back-to-back issues, then blocked at the cap until responses arrive.
        repeat (4) cycle(1, 1, 0, 0, 0, '0);
        chk("cap_pc", m_pc, RV + 32'd16);
        repeat (2) cycle(1, 1, 0, 0, 0, '0);
        repeat (6) cycle(1, 1, 1, 0, 0, '0);
        drain();

        // Ack withheld: request and address hold steady.
        repeat (3) cycle(1, 0, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, 0, '0);
        drain();

        // Three live reads flushed to 0x100.
        repeat (3) cycle(1, 1, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, 1, 32'h0000_0100);
        chk("flush_pc", m_pc, 32'h0000_0100);
        repeat (6) cycle(1, 1, 1, 0, 0, '0);
        drain();

        // Flush coinciding with a live response while two reads are live.
        repeat (2) cycle(1, 1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 1, 32'h0000_0200);
        repeat (4) cycle(0, 0, 1, 0, 0, '0);
        drain();

        // Misaligned redirect.
        cycle(1, 1, 0, 0, 1, 32'h0000_0102);
        repeat (4) cycle(1, 1, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, 1, 32'h0000_0300);

        // Access fault followed by normal fetches.
        cycle(1, 1, 0, 0, 0, '0);
        cycle(0, 0, 1, 1, 0, '0);
        repeat (3) cycle(1, 1, 0, 0, 0, '0);
        drain();

        // Random traffic with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            r   = $urandom;
            fpc = {r[31:2], ($urandom_range(5) == 0) ? 2'b10 : 2'b00};
            cycle($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(1) != 0,
                  $urandom_range(5) == 0, $urandom_range(19) == 0, fpc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_id_requester.md
# fetch_id_requester

Fetch-side counterpart of the instruction ID manager. Claims instruction IDs against `pc_id_available` (`pc_id_assigned`) and issues in-order instruction-memory reads. Returns each fetched word as `fetch_complete` plus instruction and metadata, in exactly the order the IDs were assigned. On `fetch_flush` it redirects the PC and silently discards every response still owed from memory.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h8000_0000: PC after reset.
- `MAX_OUTSTANDING`, default 4: maximum number of memory reads in flight. Must be a power of two and at least 2. Counters are `$clog2(MAX_OUTSTANDING)+1` bits wide.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `fetch_flush`, in, 1: global fetch flush / redirect.
- `flush_pc`, in, 32: redirect target, sampled when `fetch_flush` is high.
- `pc_id_available`, in, 1: the ID manager has a free ID.
- `pc_id_assigned`, out, 1: an ID is consumed this cycle for `if_pc`.
- `if_pc`, out, 32: current fetch PC.
- `mem_req`, out, 1: read request valid.
- `mem_addr`, out, 32: read address; always equals `if_pc`.
- `mem_ack`, in, 1: request accepted; only meaningful while `mem_req` is high.
- `mem_rvalid`, in, 1: in-order read response valid.
- `mem_rdata`, in, 32: response data.
- `mem_rerror`, in, 1: response is an access fault.
- `fetch_complete`, out, 1: registered completion strobe.
- `fetch_instruction`, out, 32: instruction word.
- `fetch_ok`, out, 1: metadata ok bit.
- `fetch_error_code`, out, 5: exception code, valid when `fetch_ok` is 0.

## Operation
Internal state:
- `pc`
- `live`: reads issued whose results will be delivered.
- `drop`: reads issued whose results will be discarded.
- `misaligned_pending` bit.

Issue rules:
- `can_issue` = `pc_id_available` & ~`fetch_flush` & ~`misaligned_pending` & (`live` + `drop` < `MAX_OUTSTANDING`).
- Aligned PC (`pc[1:0]` == 0): `mem_req` = `can_issue`. `pc_id_assigned` = `mem_req` & `mem_ack`. On assignment, `pc` += 4 and `live` += 1.
- Once `mem_req` rises, it stays high with a stable address until ack or flush. This is legal because `pc_id_available` cannot fall without an assignment from this block.
- Misaligned PC: no memory request is made. `pc_id_assigned` = `can_issue` and `misaligned_pending` is set. Issue then stops until a flush.

Response rules:
- `mem_rvalid` with `drop` > 0: decrement `drop`; no completion.
- `mem_rvalid` with `drop` == 0: decrement `live`. Next cycle: `fetch_complete`=1, `fetch_instruction`=`mem_rdata`, `fetch_ok`=~`mem_rerror`, `fetch_error_code` = `mem_rerror` ? 1 (instruction access fault) : 0.
- `misaligned_pending` & `live` == 0 & `drop` == 0 & ~`mem_rvalid`: next cycle, `fetch_complete`=1, `fetch_ok`=0, `fetch_error_code`=0 (instruction address misaligned), `fetch_instruction`=0. `misaligned_pending` then clears.
- At most one completion per cycle. Issue and response may occur in the same cycle; counters apply both.

Flush (`fetch_flush` high):
- `pc` <= `flush_pc`; `mem_req` = 0 and `pc_id_assigned` = 0 that cycle.
- `drop` <= `drop` + `live` - `mem_rvalid`; `live` <= 0.
- `misaligned_pending` <= 0; the `fetch_complete` register is cleared.
- Issue resumes the next cycle, even while `drop` > 0. The outstanding cap covers `live` + `drop`.

## Timing
- Reset values:
  - `if_pc` = `RESET_VECTOR`.
  - `mem_req`, `pc_id_assigned`, `fetch_complete`, `fetch_ok` = 0.
  - `fetch_instruction`, `fetch_error_code` = 0.
  - `live`, `drop`, `misaligned_pending` = 0.
- `mem_req` and `pc_id_assigned` are combinational from state, `pc_id_available`, `mem_ack` and `fetch_flush`. They are forced to 0 while `rst` is high.
- Request to assignment: same cycle as `mem_ack`; a misaligned PC is assigned the same cycle as `can_issue`.
- Response to completion: `fetch_complete` is registered, one cycle after `mem_rvalid`.
- A response arriving in the flush cycle is always discarded.
- Reset mid-transfer clears all counters. Responses after reset are the memory's responsibility and are not tracked.
- Full condition: `live` + `drop` == `MAX_OUTSTANDING` blocks issue. A response in the same cycle does not free a slot until the next cycle.

## Test plan
- Reset, then `pc_id_available`=1 and ack every cycle -> `mem_addr` 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C, one per cycle. A fifth request is blocked until the first `mem_rvalid`. Completions appear one cycle after each response, in order.
- Hold `mem_ack`=0 for 3 cycles -> `mem_req` stays 1, `mem_addr` stays stable, `pc_id_assigned` stays 0, PC does not advance.
- 3 reads live, flush to 0x100 -> next `mem_addr`=0x100. The next 3 responses produce no `fetch_complete`. The 4th response completes with 0x100's data.
- Flush in the same cycle as a live `mem_rvalid` with `live`=2 -> `drop`=1. That response and one more are discarded.
- `flush_pc`=0x102 -> one `pc_id_assigned` with no `mem_req`, then issue stops. One cycle later: `fetch_complete`=1, `fetch_ok`=0, `fetch_error_code`=0.
- Response with `mem_rerror`=1 -> `fetch_ok`=0, `fetch_error_code`=1, and subsequent fetches are unaffected.
